// File: rtl/shield_seq_ctrl_pkg.sv
// Shared security-monitor definitions: sequencer state encoding, the LFSR
// lock-up seed and default timing constants.
package shield_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SEED = 3'd1,
    ST_LOAD      = 3'd2,
    ST_WARMUP    = 3'd3,
    ST_ARMED     = 3'd4,
    ST_ZEROIZE   = 3'd5,
    ST_REKEY     = 3'd6
  } state_e;

  localparam int DEF_WARMUP_CYCLES = 4;

  // All-ones locks an XNOR LFSR; wide enough to slice for any supported width.
  localparam int                      LOCKUP_MAX_W = 256;
  localparam logic [LOCKUP_MAX_W-1:0] LOCKUP_SEED  = '1;

endpackage

// File: rtl/shield_seq_ctrl.sv
// Active-shield sequencer: seeds the LFSR, warms up the mesh loop, arms
// mismatch detection and runs the zeroize/rekey handshake on alarms.
module shield_seq_ctrl
  import shield_seq_ctrl_pkg::*;
#(
  parameter int NUM_BITS      = 32,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic                i_Clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_seed_valid,
  input  logic [NUM_BITS-1:0] i_seed_data,
  output logic                o_seed_ready,
  output logic                o_seed_err,
  output logic                o_lfsr_enable,
  output logic                o_seed_dv,
  output logic [NUM_BITS-1:0] o_seed_data,
  output logic                o_alarm_set,
  input  logic                i_alarm,
  output logic                o_zeroize_req,
  input  logic                i_zeroize_ack,
  output logic                o_master_key_ready,
  output logic                o_armed,
  output logic                o_busy,
  output logic [CNT_W-1:0]    o_alarm_count
);

  localparam logic [7:0]          WARMUP_INIT = 8'(WARMUP_CYCLES);
  localparam logic [NUM_BITS-1:0] LOCKUP      = LOCKUP_SEED[NUM_BITS-1:0];

  state_e              state_q, state_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic [NUM_BITS-1:0] seed_q, seed_d;
  logic [CNT_W-1:0]    acnt_q, acnt_d;
  logic                seed_err_q, seed_err_d;
  logic                ready_q, ready_d;
  logic                en_q, en_d;
  logic                dv_q, dv_d;
  logic                aset_q, aset_d;
  logic                zreq_q, zreq_d;
  logic                mkr_q, mkr_d;
  logic                armed_q, armed_d;
  logic                busy_q, busy_d;

  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      seed_q     <= '0;
      acnt_q     <= '0;
      seed_err_q <= 1'b0;
      ready_q    <= 1'b0;
      en_q       <= 1'b0;
      dv_q       <= 1'b0;
      aset_q     <= 1'b0;
      zreq_q     <= 1'b0;
      mkr_q      <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      seed_q     <= seed_d;
      acnt_q     <= acnt_d;
      seed_err_q <= seed_err_d;
      ready_q    <= ready_d;
      en_q       <= en_d;
      dv_q       <= dv_d;
      aset_q     <= aset_d;
      zreq_q     <= zreq_d;
      mkr_q      <= mkr_d;
      armed_q    <= armed_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    seed_d     = seed_q;
    acnt_d     = acnt_q;
    seed_err_d = 1'b0;
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_WAIT_SEED;
      ST_WAIT_SEED: begin
        // Stop abandons any seed offered in the same cycle.
        if (i_stop) state_d = ST_IDLE;
        else if (i_seed_valid) begin
          if (i_seed_data == LOCKUP) seed_err_d = 1'b1;
          else begin
            seed_d  = i_seed_data;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (i_stop) state_d = ST_IDLE;
        else begin
          wcnt_d  = WARMUP_INIT;
          state_d = ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        wcnt_d = wcnt_q - 8'd1;
        if (i_stop) state_d = ST_IDLE;
        else if (wcnt_q == 8'd1) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (i_alarm) begin
          state_d = ST_ZEROIZE;
          if (acnt_q != '1) acnt_d = acnt_q + 1'b1;
        end else if (i_stop) state_d = ST_IDLE;
      end
      ST_ZEROIZE: if (i_zeroize_ack) state_d = ST_REKEY;
      ST_REKEY:   state_d = ST_WAIT_SEED;
      default:    state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so each flop lines up with its state.
    ready_d = (state_d == ST_WAIT_SEED);
    dv_d    = (state_d == ST_LOAD);
    en_d    = (state_d == ST_LOAD) || (state_d == ST_WARMUP) ||
              (state_d == ST_ARMED) || (state_d == ST_ZEROIZE);
    aset_d  = (state_d == ST_ARMED) && (state_q == ST_WARMUP);
    armed_d = (state_d == ST_ARMED);
    zreq_d  = (state_d == ST_ZEROIZE);
    mkr_d   = (state_d == ST_REKEY);
    busy_d  = (state_d != ST_IDLE);
  end

  assign o_seed_ready       = ready_q;
  assign o_seed_err         = seed_err_q;
  assign o_lfsr_enable      = en_q;
  assign o_seed_dv          = dv_q;
  assign o_seed_data        = seed_q;
  assign o_alarm_set        = aset_q;
  assign o_zeroize_req      = zreq_q;
  assign o_master_key_ready = mkr_q;
  assign o_armed            = armed_q;
  assign o_busy             = busy_q;
  assign o_alarm_count      = acnt_q;

endmodule

// File: tb/tb_shield_seq_ctrl.sv
// Scoreboard bench for shield_seq_ctrl: accepted seeds and expected alarm counts
// are queued at stimulus time and compared when the DUT presents them.
module tb_shield_seq_ctrl;
  localparam int NB = 32;
  localparam int CW = 2;

  logic          i_Clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0, i_stop = 1'b0, i_seed_valid = 1'b0;
  logic [NB-1:0] i_seed_data = '0;
  logic          i_alarm = 1'b0, i_zeroize_ack = 1'b0;
  logic          o_seed_ready, o_seed_err, o_lfsr_enable, o_seed_dv, o_alarm_set;
  logic [NB-1:0] o_seed_data;
  logic          o_zeroize_req, o_master_key_ready, o_armed, o_busy;
  logic [CW-1:0] o_alarm_count;

  shield_seq_ctrl #(.NUM_BITS(NB), .WARMUP_CYCLES(4), .CNT_W(CW)) dut (
    .i_Clk(i_Clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_seed_valid(i_seed_valid), .i_seed_data(i_seed_data),
    .o_seed_ready(o_seed_ready), .o_seed_err(o_seed_err),
    .o_lfsr_enable(o_lfsr_enable), .o_seed_dv(o_seed_dv), .o_seed_data(o_seed_data),
    .o_alarm_set(o_alarm_set), .i_alarm(i_alarm), .o_zeroize_req(o_zeroize_req),
    .i_zeroize_ack(i_zeroize_ack), .o_master_key_ready(o_master_key_ready),
    .o_armed(o_armed), .o_busy(o_busy), .o_alarm_count(o_alarm_count)
  );

  always #5 i_Clk = ~i_Clk;

  int total = 0, bad = 0;
  logic [NB-1:0] seed_q[$];
  int            cnt_q[$];
  int            cyc = 0, load_cyc = 0;
  logic          zreq_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge i_Clk) cyc <= cyc + 1;

  // Output monitor: pops scoreboard entries as the DUT produces them.
  always @(negedge i_Clk) begin
    if (o_seed_dv) begin
      if (seed_q.size() == 0) chk("seed_dv_unexpected", 32'd1, 32'd0);
      else chk("seed_data", o_seed_data, seed_q.pop_front());
      load_cyc = cyc;
    end
    if (o_alarm_set) chk("alarm_set_latency", 32'(cyc - load_cyc), 32'd5);
    if (o_zeroize_req && !zreq_prev) begin
      if (cnt_q.size() == 0) chk("zreq_unexpected", 32'd1, 32'd0);
      else chk("alarm_count_at_zeroize", 32'(o_alarm_count), 32'(cnt_q.pop_front()));
    end
    zreq_prev = o_zeroize_req;
  end

  task automatic tick;
    @(posedge i_Clk); #1;
  endtask

  task automatic do_start;
    i_start = 1'b1; tick; i_start = 1'b0;
    chk("start_ready", 32'(o_seed_ready), 32'd1);
    chk("start_busy", 32'(o_busy), 32'd1);
  endtask

  task automatic give_seed(input logic [NB-1:0] s);
    seed_q.push_back(s);
    i_seed_valid = 1'b1; i_seed_data = s; tick; i_seed_valid = 1'b0;
    chk("load_dv", 32'(o_seed_dv), 32'd1);
    chk("load_en", 32'(o_lfsr_enable), 32'd1);
  endtask

  task automatic wait_armed;
    int n = 0;
    while (!o_armed && n < 20) begin tick; n++; end
    chk("armed_reached", 32'(o_armed), 32'd1);
    chk("aset_first", 32'(o_alarm_set), 32'd1);
    tick;
    chk("aset_single", 32'(o_alarm_set), 32'd0);
  endtask

  task automatic alarm_cycle(input int exp_cnt, input logic with_stop);
    cnt_q.push_back(exp_cnt);
    i_alarm = 1'b1; i_stop = with_stop; tick; i_alarm = 1'b0; i_stop = 1'b0;
    chk("zreq_on", 32'(o_zeroize_req), 32'd1);
    i_stop = 1'b1; i_start = 1'b1; tick; i_stop = 1'b0; i_start = 1'b0;
    repeat (6) tick;
    chk("zreq_held", 32'(o_zeroize_req), 32'd1);
    i_zeroize_ack = 1'b1; tick; i_zeroize_ack = 1'b0;
    chk("rekey_zreq_off", 32'(o_zeroize_req), 32'd0);
    chk("rekey_mkr", 32'(o_master_key_ready), 32'd1);
    chk("rekey_en", 32'(o_lfsr_enable), 32'd0);
    tick;
    chk("mkr_single", 32'(o_master_key_ready), 32'd0);
    chk("back_wait_seed", 32'(o_seed_ready), 32'd1);
    chk("alarm_count", 32'(o_alarm_count), 32'(exp_cnt));
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_seed_data", o_seed_data, 32'd0);
    chk("rst_count", 32'(o_alarm_count), 32'd0);
    chk("rst_en", 32'(o_lfsr_enable), 32'd0);
    i_rst = 1'b0; tick;

    do_start;
    give_seed(32'h1234_5678);
    wait_armed;
    i_start = 1'b1; tick; i_start = 1'b0;
    chk("start_ignored_armed", 32'(o_armed), 32'd1);
    repeat (10) tick;
    chk("no_spurious_zreq", 32'(o_zeroize_req), 32'd0);
    alarm_cycle(1, 1'b0);

    // Lock-up seed is rejected with a single error pulse.
    i_seed_valid = 1'b1; i_seed_data = 32'hFFFF_FFFF; tick; i_seed_valid = 1'b0;
    chk("lockup_err", 32'(o_seed_err), 32'd1);
    chk("lockup_stay", 32'(o_seed_ready), 32'd1);
    chk("lockup_no_dv", 32'(o_seed_dv), 32'd0);
    tick;
    chk("lockup_err_single", 32'(o_seed_err), 32'd0);
    give_seed(32'h0000_0001);
    tick; tick;
    i_stop = 1'b1; tick; i_stop = 1'b0;
    chk("stop_warmup_busy", 32'(o_busy), 32'd0);
    chk("stop_warmup_en", 32'(o_lfsr_enable), 32'd0);
    i_alarm = 1'b1; tick; i_alarm = 1'b0;
    chk("idle_alarm_nocount", 32'(o_alarm_count), 32'd1);
    i_seed_valid = 1'b1; i_seed_data = 32'hDEAD_0001; tick; i_seed_valid = 1'b0;
    chk("idle_ready_low", 32'(o_seed_ready), 32'd0);
    tick;

    do_start;
    give_seed(32'hA5A5_0001);
    wait_armed;
    alarm_cycle(2, 1'b1);
    give_seed(32'h0BAD_CAFE);
    wait_armed;
    alarm_cycle(3, 1'b0);
    give_seed(32'h7777_0000);
    wait_armed;
    alarm_cycle(3, 1'b0);

    // Reset while zeroize is pending.
    give_seed(32'h0000_00F0);
    wait_armed;
    cnt_q.push_back(3);
    i_alarm = 1'b1; tick; i_alarm = 1'b0;
    chk("pre_rst_zreq", 32'(o_zeroize_req), 32'd1);
    i_rst = 1'b1; tick; i_rst = 1'b0;
    chk("mid_rst_zreq", 32'(o_zeroize_req), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_count", 32'(o_alarm_count), 32'd0);
    chk("mid_rst_seed", o_seed_data, 32'd0);
    chk("mid_rst_en", 32'(o_lfsr_enable), 32'd0);
    tick;
    do_start;
    give_seed(32'h1357_9BDF);
    wait_armed;
    chk("restart_count", 32'(o_alarm_count), 32'd0);

    chk("seed_queue_empty", 32'(seed_q.size()), 32'd0);
    chk("cnt_queue_empty", 32'(cnt_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shield_seq_ctrl.md
Name: shield_seq_ctrl

Overview:
- Sequencer directly upstream of the security-monitor LFSR (active-shield pattern generator).
- Accepts a seed from the key/entropy source and loads it into the LFSR, runs a warm-up so the mesh round-trip pipeline fills, then arms mismatch detection.
- On a tamper alarm it drives the zeroization handshake and pulses master-key-ready to clear the LFSR alarm.
- After every alarm it forces a re-seed before re-arming.

Parameters:
- NUM_BITS, 32: LFSR/seed width; must match the LFSR instance.
- WARMUP_CYCLES, 4: enabled LFSR cycles between seed load and arming (mesh delay plus 2 compare registers); legal range 1..255.
- CNT_W, 8: width of the saturating alarm counter.

Ports:
- i_Clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  pulse; begin a seed/arm sequence from IDLE
- i_stop  in  1  pulse; abort back to IDLE (ignored in ZEROIZE)
- i_seed_valid  in  1  seed source valid
- i_seed_data  in  NUM_BITS  seed value
- o_seed_ready  out  1  seed accepted when valid&ready
- o_seed_err  out  1  1-cycle pulse; rejected all-ones seed
- o_lfsr_enable  out  1  to LFSR i_Enable
- o_seed_dv  out  1  to LFSR i_Seed_DV
- o_seed_data  out  NUM_BITS  to LFSR i_Seed_Data (held register)
- o_alarm_set  out  1  1-cycle pulse to LFSR i_alarm_set
- i_alarm  in  1  from LFSR o_alarm
- o_zeroize_req  out  1  level request to key-wipe logic
- i_zeroize_ack  in  1  wipe complete
- o_master_key_ready  out  1  1-cycle pulse to LFSR master_key_ready
- o_armed  out  1  high in ARMED
- o_busy  out  1  high in any state except IDLE
- o_alarm_count  out  CNT_W  saturating alarm count

Behaviour:
- Reset values: all outputs 0, including o_seed_data and o_alarm_count; state IDLE. Reset mid-operation drops o_zeroize_req immediately; the wipe agent tolerates an aborted request.
- All outputs are registered, Moore-style.
- IDLE
  - enable=0.
  - i_start -> WAIT_SEED.
- WAIT_SEED
  - o_seed_ready=1, enable=0.
  - On valid&ready: if seed == all-ones (XNOR lock-up), pulse o_seed_err next cycle and stay.
  - Otherwise capture the seed into o_seed_data -> LOAD.
- LOAD
  - Exactly 1 cycle: o_seed_dv=1, o_lfsr_enable=1.
  - Load warm-up counter with WARMUP_CYCLES -> WARMUP.
- WARMUP
  - enable=1; counter decrements each cycle.
  - When counter==1 -> ARMED, with o_alarm_set=1 in the first ARMED cycle only.
  - Exactly WARMUP_CYCLES cycles are spent in WARMUP.
- ARMED
  - enable=1, o_armed=1.
  - i_alarm=1 -> ZEROIZE, and o_alarm_count increments (saturates at all-ones).
  - i_stop -> IDLE.
  - i_alarm and i_stop in the same cycle: alarm wins.
- ZEROIZE
  - enable=1 (LFSR keeps running, its compare FSM is latched in ALARM), o_zeroize_req=1.
  - Waits for i_zeroize_ack; i_stop and i_start ignored.
  - On ack -> REKEY; req drops the same edge.
- REKEY
  - 1 cycle: o_master_key_ready=1, enable=0 -> WAIT_SEED.
  - The old seed is never reused.
- Stop/start handling:
  - i_stop in WAIT_SEED/LOAD/WARMUP -> IDLE; any held seed handshake is abandoned.
  - i_start outside IDLE is ignored.
- i_seed_valid outside WAIT_SEED is ignored (ready=0).
- i_alarm outside ARMED does not count.

Decomposition:
- Shared security-monitor package holds:
  - state encoding localparams (IDLE, WAIT_SEED, LOAD, WARMUP, ARMED, ZEROIZE, REKEY; 3 bits);
  - the lock-up seed constant (all-ones of NUM_BITS);
  - default WARMUP_CYCLES.
- No sub-module required. The warm-up down-counter and the saturating alarm counter stay inline.

Test Plan:
- Reset then i_start, seed 0x1234_5678 valid -> seed_ready 1 cycle later accepts; o_seed_dv=1 one cycle with o_seed_data=0x12345678; o_alarm_set pulses exactly 5 cycles after LOAD (WARMUP_CYCLES=4).
- Seed 0xFFFF_FFFF offered -> o_seed_err single pulse, stays WAIT_SEED; then seed 0x1 -> LOAD proceeds normally.
- Armed with LFSR and looped-back mesh -> no alarm over 1000 cycles. Break the loop (i_LFSR forced 0) -> i_alarm -> o_zeroize_req held until ack (ack after 7 cycles) -> o_master_key_ready one pulse -> LFSR o_alarm clears -> back in WAIT_SEED; count=1.
- i_alarm and i_stop same cycle in ARMED -> ZEROIZE entered, count increments. i_stop during ZEROIZE ignored.
- CNT_W=2, four alarm/rekey cycles -> o_alarm_count 1,2,3,3 (saturated).
- i_rst asserted mid-ZEROIZE -> next cycle all outputs 0, state IDLE; subsequent i_start restarts cleanly.
